// File: rtl/acumulador_punto_fijo_sat.sv
// Saturating fixed-point accumulator for one neuron weighted sum.
// Loads a bias, adds NumTerms signed terms over a valid/ready stream with
// clamp-to-range saturation, and presents the final sum with a sticky
// Error flag on a held valid/ready output.
module acumulador_punto_fijo_sat #(
    parameter int Width     = 24,
    parameter int Magnitud  = 4,
    parameter int Precision = 19,
    parameter int Signo     = 1,
    parameter int NumTerms  = 8,
    parameter int CountW    = $clog2(NumTerms + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [Width-1:0] Bias,
    input  logic             Abort,
    input  logic             InValid,
    input  logic [Width-1:0] In,
    output logic             InReady,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [Width-1:0] OutSum,
    output logic             Error,
    output logic             Busy
);

    // The word layout must add up; catch a bad parameter set at elaboration.
    if (Signo + Magnitud + Precision != Width) begin : g_bad_layout
        $error("Signo+Magnitud+Precision must equal Width");
    end

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [Width-1:0]  MaxVal  = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0]  MinVal  = {1'b1, {(Width-1){1'b0}}};
    localparam logic [CountW-1:0] LastIdx = CountW'(NumTerms - 1);

    state_t              state, state_n;
    logic [Width-1:0]    acc;
    logic [Width-1:0]    out_sum;
    logic [CountW-1:0]   count;
    logic                error;

    logic [Width:0]      sum_ext;
    logic                ovf, unf;
    logic [Width-1:0]    sat_sum;
    logic                accept;
    logic                last_term;

    // Outputs are pure decodes of the registered state, no input paths.
    assign InReady  = (state == ACC);
    assign OutValid = (state == DONE);
    assign Busy     = (state != IDLE);
    assign OutSum   = out_sum;
    assign Error    = error;

    assign accept    = InValid && InReady;
    assign last_term = (count == LastIdx);

    // Sign-extended add; the top two bits disagree exactly when the true
    // sum left the Width-bit range, and bit Width gives the direction.
    always_comb begin
        sum_ext = {acc[Width-1], acc} + {In[Width-1], In};
        ovf     = (sum_ext[Width:Width-1] == 2'b01);
        unf     = (sum_ext[Width:Width-1] == 2'b10);
        if (ovf)      sat_sum = MaxVal;
        else if (unf) sat_sum = MinVal;
        else          sat_sum = sum_ext[Width-1:0];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: Abort beats a same-cycle accept; Start only matters in IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (Start) state_n = ACC;
            ACC: begin
                if (Abort)                       state_n = IDLE;
                else if (accept && last_term)    state_n = DONE;
            end
            DONE: if (OutReady) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: bias load, saturating accumulate, result capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            out_sum <= '0;
            count   <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        acc   <= Bias;
                        count <= '0;
                        error <= 1'b0;
                    end
                end
                ACC: begin
                    if (!Abort && accept) begin
                        acc   <= sat_sum;
                        count <= count + CountW'(1);
                        if (ovf || unf) error <= 1'b1;
                        if (last_term)  out_sum <= sat_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_punto_fijo_sat.sv
// Self-checking bench for acumulador_punto_fijo_sat: directed saturation
// cases plus randomized sums compared against an integer reference model.
module tb_acumulador_punto_fijo_sat;

    localparam int W  = 24;
    localparam int NT = 8;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));

    logic          CLK = 0;
    logic          RST = 1;
    logic          Start = 0;
    logic [W-1:0]  Bias = '0;
    logic          Abort = 0;
    logic          InValid = 0;
    logic [W-1:0]  In = '0;
    logic          InReady;
    logic          OutValid;
    logic          OutReady = 0;
    logic [W-1:0]  OutSum;
    logic          Error;
    logic          Busy;

    int n_pass = 0;
    int n_tot  = 0;
    logic [W-1:0] terms [NT];

    acumulador_punto_fijo_sat dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Bias(Bias), .Abort(Abort),
        .InValid(InValid), .In(In), .InReady(InReady), .OutValid(OutValid),
        .OutReady(OutReady), .OutSum(OutSum), .Error(Error), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Reference: plain integer sum, clamped after every term.
    function automatic void ref_sum(input logic [W-1:0] bias,
                                    output logic [W-1:0] s, output logic e);
        longint a;
        a = $signed(bias);
        e = 1'b0;
        for (int i = 0; i < NT; i++) begin
            a = a + longint'($signed(terms[i]));
            if (a > MAXV) begin a = MAXV; e = 1'b1; end
            else if (a < MINV) begin a = MINV; e = 1'b1; end
        end
        s = W'(a);
    endfunction

    // Drives one full sum; reports what was observed, callers compare.
    task automatic run_sum(input logic [W-1:0] bias, input int gap_pct,
                           input int hold, input bit noise_in_done,
                           output logic [W-1:0] s, output logic e,
                           output bit lat_ok, output bit stab_ok,
                           output bit rdy_ok, output int n_acc);
        int  cyc;
        bit  acc_now;
        lat_ok = 1; stab_ok = 1; rdy_ok = 1; n_acc = 0; cyc = 0;
        if (InReady !== 1'b0) rdy_ok = 0;
        Start = 1; Bias = bias;
        @(posedge CLK); #1;
        Start = 0; Bias = W'($urandom);
        while (n_acc < NT && cyc < 300) begin
            InValid = ($urandom_range(99) >= gap_pct);
            In      = terms[n_acc];
            if (InReady !== 1'b1) rdy_ok = 0;
            acc_now = InValid && InReady;
            @(posedge CLK); #1;
            if (acc_now) n_acc++;
            cyc++;
        end
        InValid = 0; In = W'($urandom);
        if (OutValid !== 1'b1) lat_ok = 0;
        if (InReady !== 1'b0) rdy_ok = 0;
        s = OutSum; e = Error;
        Abort = noise_in_done; Start = noise_in_done;
        for (int i = 0; i < hold; i++) begin
            InValid = 1;
            @(posedge CLK); #1;
            if (OutValid !== 1'b1 || OutSum !== s || Error !== e) stab_ok = 0;
            if (InReady !== 1'b0) rdy_ok = 0;
        end
        InValid = 0;
        OutReady = 1;
        @(posedge CLK); #1;
        OutReady = 0; Abort = 0; Start = 0;
        if (OutValid !== 1'b0 || Busy !== 1'b0) lat_ok = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        n_tot++; if ({OutValid, InReady, Busy, Error} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {OutValid, InReady, Busy, Error}); else n_pass++;
        n_tot++; if (OutSum !== '0) $display("FAIL reset_sum got %h want 000000", OutSum); else n_pass++;
        RST = 0;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic e; bit l, st, r; int n;
        terms = '{24'h080000, 24'h100000, 24'hFC0000, 0, 0, 0, 0, 0};
        run_sum(24'h0, 0, 0, 0, s, e, l, st, r, n);
        n_tot++; if (s !== 24'h140000 || e !== 1'b0) $display("FAIL basic_sum got %h/%b want 140000/0", s, e); else n_pass++;
        n_tot++; if (!l) $display("FAIL basic_latency got late/early OutValid want 1 cycle after last accept"); else n_pass++;
        n_tot++; if (!r) $display("FAIL basic_inready got wrong InReady want 1 only in ACC"); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [W-1:0] s; logic e; bit l, st, r; int n;
        terms = '{24'h020000, 0, 0, 0, 0, 0, 0, 0};
        run_sum(24'h7F0000, 0, 0, 0, s, e, l, st, r, n);
        n_tot++; if (s !== 24'h7FFFFF || e !== 1'b1) $display("FAIL sat_high got %h/%b want 7fffff/1", s, e); else n_pass++;
        terms = '{24'hFE0000, 0, 0, 0, 0, 0, 0, 0};
        run_sum(24'h810000, 0, 0, 0, s, e, l, st, r, n);
        n_tot++; if (s !== 24'h800000 || e !== 1'b1) $display("FAIL sat_low got %h/%b want 800000/1", s, e); else n_pass++;
        terms = '{24'h020000, 24'hF80000, 0, 0, 0, 0, 0, 0};
        run_sum(24'h7F0000, 0, 0, 0, s, e, l, st, r, n);
        n_tot++; if (s !== 24'h77FFFF || e !== 1'b1) $display("FAIL sat_recover got %h/%b want 77ffff/1", s, e); else n_pass++;
    endtask

    task automatic test_random_gaps();
        logic [W-1:0] s, ms; logic e, me; bit l, st, r; int n;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NT; i++)
                terms[i] = (k < 3) ? W'($urandom) : W'($signed(W'($urandom_range(24'h1FFFFF))) - 24'sh100000);
            Bias = W'($urandom);
            ref_sum(Bias, ms, me);
            run_sum(Bias, 40, 5, (k % 2) == 1, s, e, l, st, r, n);
            n_tot++; if (s !== ms || e !== me) $display("FAIL rand_sum[%0d] got %h/%b want %h/%b", k, s, e, ms, me); else n_pass++;
            n_tot++; if (!st) $display("FAIL rand_hold_stable[%0d] got changing output want held", k); else n_pass++;
            n_tot++; if (n !== NT || !r || !l) $display("FAIL rand_handshake[%0d] got n=%0d rdy=%b lat=%b want n=%0d 1 1", k, n, r, l, NT); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] s, ms; logic e, me; bit l, st, r; int n; bit seen_valid;
        Start = 1; Bias = 24'h7F0000;
        @(posedge CLK); #1;
        Start = 0; InValid = 1; In = 24'h7F0000;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        n_tot++; if ({Busy, OutValid, InReady, Error} !== 4'b0 || OutSum !== '0) $display("FAIL rst_midsum got busy=%b ov=%b sum=%h want 0", Busy, OutValid, OutSum); else n_pass++;
        InValid = 0;
        Start = 1; Bias = 24'h7F0000;
        @(posedge CLK); #1;
        Start = 0; InValid = 1;
        repeat (5) @(posedge CLK);
        #1;
        Abort = 1;
        @(posedge CLK); #1;
        Abort = 0; InValid = 0;
        n_tot++; if (Busy !== 1'b0 || OutValid !== 1'b0) $display("FAIL abort_idle got busy=%b ov=%b want 0 0", Busy, OutValid); else n_pass++;
        seen_valid = 0;
        repeat (10) begin @(posedge CLK); #1; if (OutValid !== 1'b0) seen_valid = 1; end
        n_tot++; if (seen_valid) $display("FAIL abort_no_out got OutValid=1 want 0"); else n_pass++;
        for (int i = 0; i < NT; i++) terms[i] = W'($urandom_range(24'h00FFFF));
        ref_sum(24'h001000, ms, me);
        run_sum(24'h001000, 20, 0, 0, s, e, l, st, r, n);
        n_tot++; if (s !== ms || e !== 1'b0) $display("FAIL fresh_after_abort got %h/%b want %h/0", s, e, ms); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ms; logic me;
        for (int i = 0; i < NT; i++) terms[i] = 24'h010000;
        ref_sum(24'h020000, ms, me);
        Start = 1; Bias = 24'h020000;
        @(posedge CLK); #1;
        Bias = 24'h300000;
        InValid = 1;
        for (int i = 0; i < NT; i++) begin In = terms[i]; @(posedge CLK); #1; end
        InValid = 0;
        n_tot++; if (OutValid !== 1'b1 || OutSum !== ms) $display("FAIL b2b_first got ov=%b sum=%h want 1 %h", OutValid, OutSum, ms); else n_pass++;
        OutReady = 1;
        @(posedge CLK); #1;
        OutReady = 0;
        n_tot++; if (Busy !== 1'b0 || OutValid !== 1'b0) $display("FAIL b2b_idle_gap got busy=%b ov=%b want 0 0", Busy, OutValid); else n_pass++;
        @(posedge CLK); #1;
        Start = 0; Bias = 24'h555555;
        n_tot++; if (InReady !== 1'b1) $display("FAIL b2b_restart got InReady=%b want 1", InReady); else n_pass++;
        InValid = 1; In = '0;
        repeat (NT) @(posedge CLK);
        #1;
        InValid = 0;
        n_tot++; if (OutValid !== 1'b1 || OutSum !== 24'h300000 || Error !== 1'b0) $display("FAIL b2b_second got ov=%b sum=%h err=%b want 1 300000 0", OutValid, OutSum, Error); else n_pass++;
        OutReady = 1;
        @(posedge CLK); #1;
        OutReady = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_random_gaps();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
